// File: rtl/soc_timer_if.sv
// PicoRV32 native memory bus, as seen by one peripheral slave.
//
// Handshake: the master holds mem_valid, mem_addr, mem_wdata and mem_wstrb
// stable until it samples mem_ready=1. The slave raises mem_ready for exactly
// one cycle per accepted request. mem_rdata is meaningful only while
// mem_ready=1 and is 0 otherwise. mem_wstrb=0 marks a read.
interface soc_timer_if;
    logic        mem_valid;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
    logic        mem_ready;
    logic [31:0] mem_rdata;

    modport master (
        output mem_valid, mem_addr, mem_wdata, mem_wstrb,
        input  mem_ready, mem_rdata
    );

    modport slave (
        input  mem_valid, mem_addr, mem_wdata, mem_wstrb,
        output mem_ready, mem_rdata
    );
endinterface

// File: rtl/soc_timer.sv
// soc_timer: 32-bit timer/compare peripheral on the PicoRV32 memory bus.
// A 16-bit prescaler produces ticks; each tick advances COUNT and compares it
// against COMPARE. A match sets STATUS.pending and either reloads COUNT to 0
// or stops the timer (one-shot). irq = pending & irq_en, registered.
//
// Register map (offset = mem_addr[4:2]):
//   0x00 CTRL      [0] enable, [1] auto_reload, [2] irq_en
//   0x04 PRESCALE  [15:0]
//   0x08 COUNT     [31:0]
//   0x0C COMPARE   [31:0]
//   0x10 STATUS    [0] pending, write-1-to-clear
//   0x14-0x1C      read 0, writes ignored but acknowledged
module soc_timer #(
    parameter logic [31:0] BASE_ADDR      = 32'h0400_0000,
    parameter logic [15:0] RESET_PRESCALE = 16'd0
) (
    input  logic         clk,
    input  logic         resetn,
    soc_timer_if.slave   bus,
    output logic         irq
);

    localparam logic [2:0] OFF_CTRL     = 3'd0;
    localparam logic [2:0] OFF_PRESCALE = 3'd1;
    localparam logic [2:0] OFF_COUNT    = 3'd2;
    localparam logic [2:0] OFF_COMPARE  = 3'd3;
    localparam logic [2:0] OFF_STATUS   = 3'd4;

    // Architectural state
    logic        ctrl_enable;
    logic        ctrl_auto_reload;
    logic        ctrl_irq_en;
    logic [15:0] prescale;
    logic [31:0] count;
    logic [31:0] compare;
    logic        pending;
    logic [15:0] pre_cnt;

    // Next-state values
    logic        ctrl_enable_nxt;
    logic        ctrl_auto_reload_nxt;
    logic        ctrl_irq_en_nxt;
    logic [15:0] prescale_nxt;
    logic [31:0] count_nxt;
    logic [31:0] compare_nxt;
    logic        pending_nxt;
    logic [15:0] pre_cnt_nxt;

    // Bus decode
    logic        hit;
    logic        accept;
    logic        acc_write;
    logic [2:0]  offset;
    logic        wr_ctrl;
    logic        wr_prescale;
    logic        wr_count;
    logic        wr_compare;
    logic        wr_status_clr;
    logic [31:0] rd_data;

    // Timer events
    logic        tick;
    logic        match;

    // Byte lanes [1:0] never select a register; they are consumed here so the
    // address port is fully referenced.
    logic        unused_addr_bits;
    assign unused_addr_bits = ^bus.mem_addr[1:0];

    // Replace only the byte lanes whose strobe is set.
    function automatic logic [31:0] merge_bytes(
        input logic [31:0] old_v,
        input logic [31:0] new_v,
        input logic [3:0]  strb
    );
        logic [31:0] r;
        for (int b = 0; b < 4; b++) begin
            r[8*b +: 8] = strb[b] ? new_v[8*b +: 8] : old_v[8*b +: 8];
        end
        return r;
    endfunction

    assign hit       = bus.mem_valid && (bus.mem_addr[31:5] == BASE_ADDR[31:5]);
    // mem_ready is high in the cycle after acceptance, which blocks a second
    // acceptance of the same held request and forces one idle cycle.
    assign accept    = hit && !bus.mem_ready;
    assign acc_write = accept && (bus.mem_wstrb != 4'b0000);
    assign offset    = bus.mem_addr[4:2];

    assign wr_ctrl       = acc_write && (offset == OFF_CTRL) && bus.mem_wstrb[0];
    assign wr_prescale   = acc_write && (offset == OFF_PRESCALE) && (bus.mem_wstrb[1:0] != 2'b00);
    assign wr_count      = acc_write && (offset == OFF_COUNT);
    assign wr_compare    = acc_write && (offset == OFF_COMPARE);
    assign wr_status_clr = acc_write && (offset == OFF_STATUS) && bus.mem_wstrb[0] && bus.mem_wdata[0];

    assign tick  = ctrl_enable && (pre_cnt == prescale);
    assign match = (count == compare);

    // Read mux over the current (pre-edge) register state.
    always_comb begin
        rd_data = 32'd0;
        case (offset)
            OFF_CTRL:     rd_data = {29'd0, ctrl_irq_en, ctrl_auto_reload, ctrl_enable};
            OFF_PRESCALE: rd_data = {16'd0, prescale};
            OFF_COUNT:    rd_data = count;
            OFF_COMPARE:  rd_data = compare;
            OFF_STATUS:   rd_data = {31'd0, pending};
            default:      rd_data = 32'd0;
        endcase
    end

    // Next-state logic: hardware updates first, software writes override them,
    // and a match still sets pending over a same-cycle STATUS clear.
    always_comb begin
        ctrl_enable_nxt      = ctrl_enable;
        ctrl_auto_reload_nxt = ctrl_auto_reload;
        ctrl_irq_en_nxt      = ctrl_irq_en;
        prescale_nxt         = prescale;
        count_nxt            = count;
        compare_nxt          = compare;
        pending_nxt          = pending;
        pre_cnt_nxt          = pre_cnt;

        // Prescaler: held at 0 while disabled; 16-bit wrap lets a lowered
        // PRESCALE still be reached after passing through 0xFFFF.
        if (!ctrl_enable) begin
            pre_cnt_nxt = 16'd0;
        end else if (tick) begin
            pre_cnt_nxt = 16'd0;
        end else begin
            pre_cnt_nxt = pre_cnt + 16'd1;
        end

        // Counter and one-shot stop on a tick
        if (tick) begin
            if (match && ctrl_auto_reload) begin
                count_nxt = 32'd0;
            end else begin
                count_nxt = count + 32'd1;
            end
            if (match && !ctrl_auto_reload) begin
                ctrl_enable_nxt = 1'b0;
            end
        end

        // Software writes
        if (wr_ctrl) begin
            ctrl_enable_nxt      = bus.mem_wdata[0];
            ctrl_auto_reload_nxt = bus.mem_wdata[1];
            ctrl_irq_en_nxt      = bus.mem_wdata[2];
        end
        if (wr_prescale) begin
            prescale_nxt = merge_bytes({16'd0, prescale}, bus.mem_wdata, bus.mem_wstrb) & 32'h0000_FFFF;
        end
        if (wr_count) begin
            count_nxt = merge_bytes(count, bus.mem_wdata, bus.mem_wstrb);
        end
        if (wr_compare) begin
            compare_nxt = merge_bytes(compare, bus.mem_wdata, bus.mem_wstrb);
        end

        // Pending: clear, then let a match set it again
        if (wr_status_clr) begin
            pending_nxt = 1'b0;
        end
        if (tick && match) begin
            pending_nxt = 1'b1;
        end
    end

    // Register file, prescaler, counter and registered irq
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            ctrl_enable      <= 1'b0;
            ctrl_auto_reload <= 1'b0;
            ctrl_irq_en      <= 1'b0;
            prescale         <= RESET_PRESCALE;
            count            <= 32'd0;
            compare          <= 32'd0;
            pending          <= 1'b0;
            pre_cnt          <= 16'd0;
            irq              <= 1'b0;
        end else begin
            ctrl_enable      <= ctrl_enable_nxt;
            ctrl_auto_reload <= ctrl_auto_reload_nxt;
            ctrl_irq_en      <= ctrl_irq_en_nxt;
            prescale         <= prescale_nxt;
            count            <= count_nxt;
            compare          <= compare_nxt;
            pending          <= pending_nxt;
            pre_cnt          <= pre_cnt_nxt;
            irq              <= pending_nxt & ctrl_irq_en_nxt;
        end
    end

    // One-cycle registered acknowledge; read data captured at acceptance
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            bus.mem_ready <= 1'b0;
            bus.mem_rdata <= 32'd0;
        end else begin
            bus.mem_ready <= accept;
            bus.mem_rdata <= accept ? rd_data : 32'd0;
        end
    end

endmodule

// File: tb/tb_soc_timer.sv
// Testbench for soc_timer: directed bus accesses, with read expectations
// pushed into a scoreboard queue and popped by a monitor on each mem_ready.
module tb_soc_timer;

    localparam logic [31:0] BASE    = 32'h0400_0000;
    localparam logic [15:0] RST_PRE = 16'h00A5;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic resetn;
    logic irq;
    int   cyc = 0;

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    soc_timer_if mem_bus ();

    soc_timer #(
        .BASE_ADDR      (BASE),
        .RESET_PRESCALE (RST_PRE)
    ) dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (mem_bus),
        .irq    (irq)
    );

    // ---------------- scoreboard ----------------
    int          checks   = 0;
    int          failures = 0;
    int          ack_cnt  = 0;
    logic [31:0] exp_q[$];
    bit          chk_q[$];
    string       name_q[$];

    logic [31:0] mon_exp;
    bit          mon_chk;
    string       mon_name;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Monitor: every acknowledge consumes one scoreboard entry
    always @(negedge clk) begin
        if (resetn === 1'b1 && mem_bus.mem_ready === 1'b1) begin
            ack_cnt++;
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_ack: got ack rdata 0x%08h expected no ack", mem_bus.mem_rdata);
            end else begin
                mon_exp  = exp_q.pop_front();
                mon_chk  = chk_q.pop_front();
                mon_name = name_q.pop_front();
                if (mon_chk) check(mon_name, mem_bus.mem_rdata, mon_exp);
            end
        end
    end

    // ---------------- driver tasks ----------------
    // Called at a negedge; returns at a negedge two cycles later with the bus idle.
    task automatic bus_access(input logic [31:0] addr, input logic [31:0] wdata, input logic [3:0] wstrb);
        mem_bus.mem_valid = 1'b1;
        mem_bus.mem_addr  = addr;
        mem_bus.mem_wdata = wdata;
        mem_bus.mem_wstrb = wstrb;
        @(posedge clk);
        @(negedge clk);
        mem_bus.mem_valid = 1'b0;
        mem_bus.mem_wstrb = 4'b0000;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic bus_write(input logic [7:0] off, input logic [31:0] data, input logic [3:0] strb);
        exp_q.push_back(32'd0);
        chk_q.push_back(1'b0);
        name_q.push_back("write");
        bus_access(BASE + {24'd0, off}, data, strb);
    endtask

    task automatic bus_read(input logic [7:0] off, input logic [31:0] exp, input string name);
        exp_q.push_back(exp);
        chk_q.push_back(1'b1);
        name_q.push_back(name);
        bus_access(BASE + {24'd0, off}, 32'd0, 4'b0000);
    endtask

    task automatic wait_irq(input int budget, input string name, output int t);
        int n;
        n = 0;
        while (irq !== 1'b1 && n < budget) begin
            @(negedge clk);
            n++;
        end
        check(name, {31'd0, irq}, 32'd1);
        t = cyc;
    endtask

    // ---------------- directed sequence ----------------
    int          t1, t2, a0;
    logic        hs_exp[4];

    initial begin
        hs_exp[0] = 1'b1; hs_exp[1] = 1'b0; hs_exp[2] = 1'b1; hs_exp[3] = 1'b0;
        resetn            = 1'b0;
        mem_bus.mem_valid = 1'b0;
        mem_bus.mem_addr  = 32'd0;
        mem_bus.mem_wdata = 32'd0;
        mem_bus.mem_wstrb = 4'b0000;
        repeat (3) @(negedge clk);
        check("rst_irq", {31'd0, irq}, 32'd0);
        check("rst_ready", {31'd0, mem_bus.mem_ready}, 32'd0);
        resetn = 1'b1;
        @(negedge clk);

        // Handshake and byte strobes
        bus_write(8'h0C, 32'h1234_5678, 4'b0011);
        bus_read(8'h0C, 32'h0000_5678, "compare_strb");
        mem_bus.mem_valid = 1'b1;
        mem_bus.mem_addr  = BASE + 32'h0C;
        mem_bus.mem_wstrb = 4'b0000;
        exp_q.push_back(32'h0000_5678); chk_q.push_back(1'b1); name_q.push_back("hold_rd0");
        exp_q.push_back(32'h0000_5678); chk_q.push_back(1'b1); name_q.push_back("hold_rd1");
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check($sformatf("hold_ready%0d", i), {31'd0, mem_bus.mem_ready}, {31'd0, hs_exp[i]});
        end
        mem_bus.mem_valid = 1'b0;

        // Auto-reload: period (3+1)*(4+1) = 20 cycles
        bus_write(8'h04, 32'd3, 4'hF);
        bus_write(8'h0C, 32'd4, 4'hF);
        bus_write(8'h08, 32'd0, 4'hF);
        bus_write(8'h00, 32'h7, 4'hF);
        wait_irq(40, "ar_irq1", t1);
        bus_read(8'h08, 32'd0, "ar_count_reload");
        bus_write(8'h10, 32'd1, 4'b0001);
        check("ar_irq_clear", {31'd0, irq}, 32'd0);
        wait_irq(40, "ar_irq2", t2);
        check("ar_period", t2 - t1, 32'd20);

        // Asynchronous reset mid-cycle while irq is high
        #2 resetn = 1'b0;
        #1;
        check("midrst_irq", {31'd0, irq}, 32'd0);
        check("midrst_ready", {31'd0, mem_bus.mem_ready}, 32'd0);
        @(negedge clk);
        @(negedge clk);
        resetn = 1'b1;
        @(negedge clk);
        bus_read(8'h00, 32'd0, "rst_ctrl");
        bus_read(8'h04, {16'd0, RST_PRE}, "rst_prescale");
        bus_read(8'h08, 32'd0, "rst_count");
        bus_read(8'h0C, 32'd0, "rst_compare");
        bus_read(8'h10, 32'd0, "rst_status");

        // One-shot: COUNT 0->1->2, match at 2 -> COUNT 3, enable off
        bus_write(8'h04, 32'd0, 4'hF);
        bus_write(8'h0C, 32'd2, 4'hF);
        bus_write(8'h00, 32'h5, 4'hF);
        wait_irq(20, "os_irq", t1);
        bus_read(8'h00, 32'h4, "os_ctrl");
        bus_read(8'h08, 32'd3, "os_count");
        repeat (5) @(negedge clk);
        bus_read(8'h08, 32'd3, "os_count_frozen");
        bus_write(8'h10, 32'd1, 4'b0001);
        check("os_irq_clear", {31'd0, irq}, 32'd0);
        repeat (20) @(negedge clk);
        check("os_single", {31'd0, irq}, 32'd0);

        // STATUS clear lands on the matching tick: set wins
        bus_write(8'h0C, 32'd3, 4'hF);
        bus_write(8'h08, 32'd0, 4'hF);
        bus_write(8'h00, 32'h1, 4'hF);
        repeat (2) @(negedge clk);
        bus_write(8'h10, 32'd1, 4'b0001);
        bus_read(8'h10, 32'd1, "col_status_set_wins");
        bus_read(8'h08, 32'd4, "col_count_oneshot");

        // COUNT write lands on a tick (PRESCALE=2, tick every 3 cycles)
        bus_write(8'h10, 32'd1, 4'b0001);
        bus_write(8'h04, 32'd2, 4'hF);
        bus_write(8'h0C, 32'h100, 4'hF);
        bus_write(8'h08, 32'd0, 4'hF);
        bus_write(8'h00, 32'h3, 4'hF);
        @(negedge clk);
        bus_write(8'h08, 32'h10, 4'hF);
        bus_read(8'h08, 32'h10, "col_count_write_wins");
        bus_write(8'h00, 32'h0, 4'hF);

        // Wrap 0xFFFF_FFFF -> 0 without pending
        bus_write(8'h04, 32'd0, 4'hF);
        bus_write(8'h0C, 32'd5, 4'hF);
        bus_write(8'h08, 32'hFFFF_FFFF, 4'hF);
        bus_write(8'h00, 32'h1, 4'hF);
        bus_read(8'h08, 32'd0, "wrap_count");
        bus_write(8'h00, 32'h0, 4'hF);
        bus_read(8'h10, 32'd0, "wrap_no_pending");

        // Address window
        a0 = ack_cnt;
        bus_write(8'h18, 32'hDEAD_BEEF, 4'hF);
        check("ack_0x18", ack_cnt, a0 + 1);
        bus_read(8'h18, 32'd0, "rsvd_read");
        a0 = ack_cnt;
        bus_access(BASE + 32'h20, 32'h7, 4'hF);
        check("no_ack_0x20", ack_cnt, a0);
        bus_read(8'h00, 32'd0, "ctrl_not_aliased");
        bus_write(8'h04, 32'hFFFF_1234, 4'hF);
        bus_read(8'h04, 32'h0000_1234, "prescale_upper");

        repeat (2) @(negedge clk);
        check("queue_empty", exp_q.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Global watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected finish before 200000");
        $fatal(1, "watchdog expired");
    end

endmodule
